latency_ram_arbiter: RTL
========================

Name: latency_ram_arbiter

Overview:
- Two-requester arbiter sharing one LatencyRam-style backing memory between the instruction-side and data-side caches of the 5-stage RISC-V core.
- Sits between the caches' mem_req_*/mem_res_* ports and the single RAM instance.
- Grants one requester at a time and holds the grant for a full transaction until the RAM signals completion.
- Forces one idle cycle between transactions so the RAM's latency counter re-arms.

Parameters:
- ADDR_WIDTH, 32, width of request address.
- DATA_WIDTH, 32, width of write/read data.
- FIXED_PRIORITY, 0: 0 = round-robin; 1 = port 1 (data side) always wins ties.

Ports:
- clk  in  1  single clock, rising edge. Clock named clk, reset named rst. Reset is asynchronous and active-high.
- rst  in  1  asynchronous, active-high reset.
- req0_addr  in  ADDR_WIDTH  port 0 (I-cache) address.
- req0_data  in  DATA_WIDTH  port 0 write data.
- req0_wen  in  1  port 0 write enable.
- req0_valid  in  1  port 0 request; held high until res0_valid.
- res0_data  out  DATA_WIDTH  read data to port 0.
- res0_valid  out  1  one-cycle completion pulse to port 0.
- req1_addr, req1_data, req1_wen, req1_valid, res1_data, res1_valid: same as port 0, for port 1 (D-cache).
- mem_req_addr  out  ADDR_WIDTH  address to RAM.
- mem_req_data  out  DATA_WIDTH  write data to RAM.
- mem_req_wen  out  1  RAM write enable.
- mem_req_valid  out  1  RAM enable; held high for the whole transaction.
- mem_res_data  in  DATA_WIDTH  RAM read data.
- mem_res_valid  in  1  RAM finish flag.

Behaviour:
- States: IDLE, GRANT0, GRANT1, RELEASE; state register reset to IDLE. last_grant resets to 1, so port 0 wins the first tie.
- Reset values: mem_req_valid=0, mem_req_wen=0, mem_req_addr=0, mem_req_data=0, res0/1_valid=0, res0/1_data=0.
- Arbitration (IDLE only):
  - Only reqN_valid high -> GRANTN next edge.
  - Both high, FIXED_PRIORITY=0 -> grant the port != last_grant.
  - Both high, FIXED_PRIORITY=1 -> GRANT1.
  - last_grant is updated on entry to GRANTx.
- GRANTx:
  - mem_req_addr/data/wen are combinationally muxed from port x.
  - mem_req_valid = reqx_valid. Grant latency is 1 cycle from valid to mem_req_valid.
  - resx_valid = mem_res_valid (combinational), resx_data = mem_res_data. The other port's res is 0.
  - mem_res_valid high -> RELEASE.
  - reqx_valid dropping before completion (abort) -> RELEASE, with no res pulse.
- RELEASE: mem_req_valid=0 for exactly one cycle, then -> IDLE. Minimum turnaround between transactions is 2 cycles (RELEASE + IDLE).
- Idle outputs: outside GRANTx, mem_req_* = 0 and res*_valid = 0.
- Requesters must hold addr/data/wen stable while valid; the arbiter does not latch them.
- mem_res_valid asserted outside GRANTx is ignored.
- Simultaneous mem_res_valid and reqx_valid fall in the same cycle: completion wins and the res pulse is delivered.
- Async reset mid-transaction: immediate return to IDLE; mem_req_valid drops in the same cycle; no res pulse.
- No starvation under round-robin: a continuously asserting port waits at most one full transaction of the other port.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs grant0_cnt[31:0], grant1_cnt[31:0] (increment on entry to GRANTx).
  - Adds outputs wait0_cnt[31:0], wait1_cnt[31:0] (increment each cycle reqx_valid=1 while not in GRANTx).
  - All counters reset to 0, saturate at 32'hFFFF_FFFF, and have no functional effect.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package latency_ram_arbiter_pkg:
  - state encoding constants (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2, RELEASE=2'd3).
  - port index constants PORT_I=0, PORT_D=1.
- One natural sub-module: rr_pick_2.
  - Combinational: inputs valid0, valid1, last_grant, fixed_priority.
  - Outputs: grant_any, grant_idx.
  - Reusable for later arbiters.

Test Plan:
- Single read on port 0: req0_valid=1, addr=0x40, RAM returns 0xDEADBEEF after 3 cycles -> mem_req_valid rises 1 cycle after req0_valid; res0_valid pulses 1 cycle with res0_data=0xDEADBEEF; mem_req_valid=0 in the following (RELEASE) cycle.
- Simultaneous requests, round-robin, after reset: port 0 read 0x10 and port 1 write 0x20=0x1234 both asserted -> port 0 served first; port 1 granted 2 cycles after res0_valid; RAM sees wen=1, addr=0x20, data=0x1234.
- Back-to-back from both ports for 4 transactions each -> grants alternate 0,1,0,1,...; no port is granted twice in a row while the other is waiting.
- FIXED_PRIORITY=1, both valid repeatedly -> port 1 always wins ties; port 0 is served only when req1_valid=0 in IDLE.
- Abort: req1_valid drops during GRANT1 before mem_res_valid -> RELEASE next cycle, res1_valid never pulses, and a late mem_res_valid is ignored.
- Reset mid-GRANT0: assert rst -> mem_req_valid=0 immediately, state=IDLE; with ARB_PERF_CNT_EN defined, all counters read 0.

Source files
------------

// File: rtl/latency_ram_arbiter_pkg.sv
// rtl/latency_ram_arbiter_pkg.sv - shared state encoding, port indices and counter helper for the RAM arbiter
// Contents: arb_state_t (IDLE/GRANT0/GRANT1/RELEASE), PORT_I/PORT_D indices,
//           CNT_MAX and sat_inc() used by the optional performance counters.
`timescale 1ns/1ps
package latency_ram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT0  = 2'd1,
        GRANT1  = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    localparam logic PORT_I = 1'b0;  // instruction-side cache
    localparam logic PORT_D = 1'b1;  // data-side cache

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CNT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/latency_ram_arbiter_rr_pick_2.sv
// rtl/latency_ram_arbiter_rr_pick_2.sv - combinational two-way round-robin / fixed-priority picker
// Ports:
//   valid0, valid1  : request lines of port 0 / port 1
//   last_grant      : index of the port granted most recently
//   fixed_priority  : 1 = port 1 wins ties, 0 = alternate on ties
//   grant_any       : at least one request present
//   grant_idx       : index of the winning port (meaningful when grant_any=1)
`timescale 1ns/1ps
module rr_pick_2
    import latency_ram_arbiter_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    input  logic fixed_priority,
    output logic grant_any,
    output logic grant_idx
);

    always_comb begin
        grant_any = valid0 | valid1;
        grant_idx = PORT_I;
        if (valid0 && valid1) begin
            // On a tie the port that did not go last wins, unless port 1 is pinned.
            grant_idx = fixed_priority ? PORT_D : ~last_grant;
        end else if (valid1) begin
            grant_idx = PORT_D;
        end
    end

endmodule

// File: rtl/latency_ram_arbiter.sv
// rtl/latency_ram_arbiter.sv - shares one latency RAM between the I-cache (port 0) and D-cache (port 1)
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   reqN_addr/data/wen/valid      : request from port N, held stable until resN_valid
//   resN_data/resN_valid          : read data and one-cycle completion pulse to port N
//   mem_req_addr/data/wen/valid   : request to the RAM, valid held for the whole transaction
//   mem_res_data/mem_res_valid    : RAM read data and finish flag
// Optional (macro ARB_PERF_CNT_EN): grant0_cnt, grant1_cnt, wait0_cnt, wait1_cnt
//   saturating 32-bit grant and wait-cycle counters.
`timescale 1ns/1ps
module latency_ram_arbiter
    import latency_ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req0_wen,
    input  logic                  req0_valid,
    output logic [DATA_WIDTH-1:0] res0_data,
    output logic                  res0_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic                  req1_wen,
    input  logic                  req1_valid,
    output logic [DATA_WIDTH-1:0] res1_data,
    output logic                  res1_valid,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_data,
    output logic                  mem_req_wen,
    output logic                  mem_req_valid,
    input  logic [DATA_WIDTH-1:0] mem_res_data,
    input  logic                  mem_res_valid
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]           grant0_cnt,
    output logic [31:0]           grant1_cnt,
    output logic [31:0]           wait0_cnt,
    output logic [31:0]           wait1_cnt
`endif
);

    arb_state_t state;
    logic       last_grant;
    logic       pick_any;
    logic       pick_idx;

    rr_pick_2 u_pick (
        .valid0         (req0_valid),
        .valid1         (req1_valid),
        .last_grant     (last_grant),
        .fixed_priority (FIXED_PRIORITY != 0),
        .grant_any      (pick_any),
        .grant_idx      (pick_idx)
    );

    // Completion has priority over an abort in the same cycle: both leave via
    // RELEASE, and the response mux below already forwards the pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= PORT_D;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state      <= (pick_idx == PORT_D) ? GRANT1 : GRANT0;
                        last_grant <= pick_idx;
                    end
                end
                GRANT0: begin
                    if (mem_res_valid || !req0_valid) state <= RELEASE;
                end
                GRANT1: begin
                    if (mem_res_valid || !req1_valid) state <= RELEASE;
                end
                RELEASE: begin
                    // One dead cycle lets the RAM latency counter re-arm.
                    state <= IDLE;
                end
            endcase
        end
    end

    // Requests and responses are steered combinationally from the granted
    // port; requesters hold their fields stable, so nothing is latched here.
    // Since the mux keys off the state register, an async reset drops
    // mem_req_valid in the same cycle.
    always_comb begin
        mem_req_addr  = '0;
        mem_req_data  = '0;
        mem_req_wen   = 1'b0;
        mem_req_valid = 1'b0;
        res0_data     = '0;
        res0_valid    = 1'b0;
        res1_data     = '0;
        res1_valid    = 1'b0;
        case (state)
            GRANT0: begin
                mem_req_addr  = req0_addr;
                mem_req_data  = req0_data;
                mem_req_wen   = req0_wen;
                mem_req_valid = req0_valid;
                res0_data     = mem_res_data;
                res0_valid    = mem_res_valid;
            end
            GRANT1: begin
                mem_req_addr  = req1_addr;
                mem_req_data  = req1_data;
                mem_req_wen   = req1_wen;
                mem_req_valid = req1_valid;
                res1_data     = mem_res_data;
                res1_valid    = mem_res_valid;
            end
            default: begin
            end
        endcase
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant0_cnt <= '0;
            grant1_cnt <= '0;
            wait0_cnt  <= '0;
            wait1_cnt  <= '0;
        end else begin
            if (state == IDLE && pick_any && pick_idx == PORT_I) grant0_cnt <= sat_inc(grant0_cnt);
            if (state == IDLE && pick_any && pick_idx == PORT_D) grant1_cnt <= sat_inc(grant1_cnt);
            if (req0_valid && state != GRANT0) wait0_cnt <= sat_inc(wait0_cnt);
            if (req1_valid && state != GRANT1) wait1_cnt <= sat_inc(wait1_cnt);
        end
    end
`endif

endmodule
